btn_conditioner: RTL and testbench
==================================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning the number of stable synchronized-input cycles required to accept an edge (minimum 2).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer flop depth (minimum 2).
REQ-003 SHALL have parameter LONG_CYCLES, default 100000000, meaning the number of held cycles after acceptance that constitutes a long press.
REQ-004 SHALL have port clk, input, 1, the single system clock; every flop is on its rising edge.
REQ-005 SHALL have port reset, input, 1, the asynchronous active-low reset.
REQ-006 SHALL have port btn_raw, input, 1, the raw asynchronous push-button level (startstop source).
REQ-007 SHALL have port run_clr, input, 1, a synchronous clear of run, sampled on clk.
REQ-008 SHALL have port btn_level, output, 1, the debounced button level.
REQ-009 SHALL have port btn_press, output, 1, a one-cycle pulse on each accepted press.
REQ-010 SHALL have port btn_long, output, 1, a one-cycle pulse on a long press.
REQ-011 SHALL have port run, output, 1, the stopwatch run/stop level that drives the downstream startstop input.

Function
REQ-012 SHALL pass btn_raw through SYNC_STAGES flops; the FSM sees only the last stage (sync_q).
REQ-013 SHALL implement the states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT with one debounce counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-014 SHALL handle IDLE as follows: sync_q=1 -> PRESS_WAIT with counter=0; otherwise stay.
REQ-015 SHALL handle PRESS_WAIT as follows: sync_q=0 -> IDLE with counter=0 and no output change; counter==DEBOUNCE_CYCLES-1 -> PRESSED; otherwise counter+1.
REQ-016 SHALL handle PRESSED as follows: sync_q=0 -> RELEASE_WAIT with counter=0; otherwise stay.
REQ-017 SHALL handle RELEASE_WAIT as follows: sync_q=1 -> PRESSED with no pulse; counter==DEBOUNCE_CYCLES-1 -> IDLE; otherwise counter+1.
REQ-018 SHALL make btn_level registered, 1 exactly while the state is PRESSED or RELEASE_WAIT.
REQ-019 SHALL assert btn_press, registered, for exactly the first cycle of PRESSED entered from PRESS_WAIT; if edge N is the first to sample btn_raw=1 and the input stays stable, btn_press is high in the cycle after edge N+SYNC_STAGES+DEBOUNCE_CYCLES.
REQ-020 SHALL toggle run on the cycle after btn_press; run_clr=1 forces run=0 on the next edge and wins over a simultaneous toggle.
REQ-021 SHALL ensure that a glitch shorter than DEBOUNCE_CYCLES in either direction produces no pulse and no run or btn_level change.
REQ-022 SHALL saturate counters; they SHALL never wrap.

Reset
REQ-023 SHALL, while reset=0, asynchronously clear all synchronizer flops, place the FSM in IDLE, set counters to 0, and drive btn_level=0, btn_press=0, btn_long=0 and run=0.
REQ-024 SHALL, on reset deassertion with btn_raw held high, treat the press as new: btn_press fires after full synchronization and debounce.
REQ-025 SHALL, if reset is asserted mid-debounce or mid-long-count, discard all progress with no pulse.

Configuration
REQ-026 SHALL, with macro BTN_LONG_PRESS_EN defined, count held cycles in PRESSED from 0 and pulse btn_long once when the count reaches LONG_CYCLES-1; the same cycle forces run=0 on the next edge; there is no repeat until release is accepted; the count restarts on every PRESSED entry.
REQ-027 SHALL, without BTN_LONG_PRESS_EN, tie btn_long to constant 0, omit the long counter, and ignore LONG_CYCLES.

Structure
REQ-028 SHALL place the FSM state enum (btn_state_t) and default parameter constants in shared package btn_pkg.
REQ-029 SHALL implement the synchronizer as sub-module sync_ff, parameterized by STAGES, with the same asynchronous active-low reset.

Verification
REQ-030 SHALL cover the following scenario (DEBOUNCE_CYCLES=4, SYNC_STAGES=2): btn_raw rises before edge 0 and stays high -> btn_press high for exactly the cycle after edge 6, btn_level=1, and run 0->1.
REQ-031 SHALL cover the following scenario: btn_raw high for 3 cycles then low -> no btn_press, and run and btn_level unchanged.
REQ-032 SHALL cover the following scenario: press accepted, then a 2-cycle low glitch, then high -> btn_level stays 1 with no second btn_press; a later 4-cycle-stable release is followed by a second press, giving run 1->0.
REQ-033 SHALL cover the following scenario: run_clr=1 in the same cycle as btn_press with run=0 -> run remains 0.
REQ-034 SHALL cover the following scenario (BTN_LONG_PRESS_EN defined, LONG_CYCLES=8): hold for 20 cycles after acceptance -> one btn_long pulse 8 cycles into PRESSED and run=0; without the macro, btn_long=0 throughout.
REQ-035 SHALL cover the following scenario: reset=0 asserted during PRESS_WAIT -> all outputs 0 immediately with no clock edge needed; release with btn_raw high -> btn_press after 6 more edges.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and default constants for the push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_LONG_CYCLES     = 100000000;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer that brings an asynchronous level into the clk domain.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_ff: STAGES must be at least 2");
  end

  logic [STAGES-1:0] stages;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stages <= '0;
    else        stages <= {stages[STAGES-2:0], d};
  end

  assign q = stages[STAGES-1];

endmodule

// File: rtl/btn_conditioner.sv
// Debounces a raw push button, emits press/long-press pulses and a run/stop level.
// Optional long-press detection is built only when BTN_LONG_PRESS_EN is defined.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic run_clr,
  output logic btn_level,
  output logic btn_press,
  output logic btn_long,
  output logic run
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("btn_conditioner: DEBOUNCE_CYCLES must be at least 2");
  end
  if (LONG_CYCLES < 1) begin : g_bad_long
    $error("btn_conditioner: LONG_CYCLES must be at least 1");
  end

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic       sync_q;
  btn_state_t state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic       press_next;
  logic       level_next;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_raw),
    .q     (sync_q)
  );

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    press_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (sync_q) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync_q) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = PRESSED;
          cnt_next   = '0;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!sync_q) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        // A bounce back high resumes the held press without a new pulse.
        if (sync_q) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    level_next = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_press <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      btn_level <= level_next;
      btn_press <= press_next;
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] long_cnt;
  logic          long_done;
  logic          enter_pressed;
  logic          stay_pressed;
  logic          long_next;

  assign enter_pressed = (state_next == PRESSED) && (state != PRESSED);
  assign stay_pressed  = (state == PRESSED) && (state_next == PRESSED);
  // long_done blocks repeats until the release is fully accepted, even across bounces.
  assign long_next     = stay_pressed && (long_cnt == LONG_LAST) && !long_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      long_cnt  <= '0;
      long_done <= 1'b0;
      btn_long  <= 1'b0;
    end else begin
      btn_long <= long_next;
      if (enter_pressed) long_cnt <= '0;
      else if (stay_pressed && long_cnt != LONG_LAST) long_cnt <= long_cnt + 1'b1;
      if (state_next == IDLE) long_done <= 1'b0;
      else if (long_next)     long_done <= 1'b1;
    end
  end
`else
  assign btn_long = 1'b0;
`endif

  // A clear or a long press wins over a toggle requested in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 run <= 1'b0;
    else if (run_clr || btn_long) run <= 1'b0;
    else if (btn_press)         run <= ~run;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2, LONG_CYCLES=8.
module tb_btn_conditioner;

  localparam int DEB  = 4;
  localparam int SYNC = 2;
  localparam int LONG = 8;
  // Press becomes visible SYNC+DEB edges after the first edge that samples the rise.
  localparam int PRESS_LAT = 1 + SYNC + DEB;

`ifdef BTN_LONG_PRESS_EN
  localparam int LONG_EXP = 1;
`else
  localparam int LONG_EXP = 0;
`endif

  typedef struct {
    int   cyc;
    logic run;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic btn_raw;
  logic run_clr;
  logic btn_level;
  logic btn_press;
  logic btn_long;
  logic run;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   long_count = 0;
  int   long_cyc = -1;
  exp_t exp_q[$];

  btn_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .SYNC_STAGES     (SYNC),
    .LONG_CYCLES     (LONG)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .run_clr   (run_clr),
    .btn_level (btn_level),
    .btn_press (btn_press),
    .btn_long  (btn_long),
    .run       (run)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_press(input logic run_after);
    exp_t e;
    e.cyc = cyc + PRESS_LAT;
    e.run = run_after;
    exp_q.push_back(e);
  endtask

  task automatic idle_low(input int n);
    btn_raw = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic press_hold(input int hold, input logic run_after);
    btn_raw = 1'b1;
    expect_press(run_after);
    repeat (hold) @(negedge clk);
    btn_raw = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every press pulse, checks run one cycle later.
  initial begin : monitor
    logic run_pending;
    logic run_exp;
    exp_t e;
    run_pending = 1'b0;
    run_exp     = 1'b0;
    forever begin
      @(negedge clk);
      if (run_pending) begin
        check("run_after_press", int'(run), int'(run_exp));
        run_pending = 1'b0;
      end
      if (btn_long === 1'b1) begin
        long_count++;
        long_cyc = cyc;
      end
      if (btn_press === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_press: btn_press=1 at cycle %0d, none expected", cyc);
        end else begin
          e = exp_q.pop_front();
          check("press_cycle", cyc, e.cyc);
          check("level_at_press", int'(btn_level), 1);
          run_pending = 1'b1;
          run_exp     = e.run;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int c;
    reset   = 1'b0;
    btn_raw = 1'b0;
    run_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_level", int'(btn_level), 0);
    check("reset_press", int'(btn_press), 0);
    check("reset_long", int'(btn_long), 0);
    check("reset_run", int'(run), 0);
    reset = 1'b1;
    idle_low(4);

    // Clean press: pulse exactly PRESS_LAT cycles after driving, run 0->1.
    press_hold(9, 1'b1);
    check("level_held", int'(btn_level), 1);
    idle_low(10);
    check("level_released", int'(btn_level), 0);

    // Short high glitch: nothing may change.
    btn_raw = 1'b1;
    repeat (3) @(negedge clk);
    idle_low(10);
    check("glitch_level", int'(btn_level), 0);
    check("glitch_run", int'(run), 1);

    // Standalone clear.
    run_clr = 1'b1;
    @(negedge clk);
    run_clr = 1'b0;
    check("run_clr_alone", int'(run), 0);
    idle_low(2);

    // Accepted press, 2-cycle low bounce, still held; then release and press again.
    btn_raw = 1'b1;
    expect_press(1'b1);
    repeat (9) @(negedge clk);
    btn_raw = 1'b0;
    repeat (2) @(negedge clk);
    btn_raw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("bounce_level", int'(btn_level), 1);
      @(negedge clk);
    end
    idle_low(10);
    check("bounce_released", int'(btn_level), 0);
    press_hold(9, 1'b0);
    idle_low(10);

    // Clear coincident with the press pulse while run=0.
    btn_raw = 1'b1;
    expect_press(1'b0);
    repeat (PRESS_LAT) @(negedge clk);
    run_clr = 1'b1;
    @(negedge clk);
    run_clr = 1'b0;
    @(negedge clk);
    btn_raw = 1'b0;
    idle_low(10);
    check("clr_vs_press_run", int'(run), 0);

    // Long hold: 20 cycles beyond acceptance.
    c = cyc;
    btn_raw = 1'b1;
    expect_press(1'b1);
    repeat (PRESS_LAT + 20) @(negedge clk);
    check("long_level", int'(btn_level), 1);
    check("long_run", int'(run), LONG_EXP ? 0 : 1);
`ifdef BTN_LONG_PRESS_EN
    check("long_pulse_cycle", long_cyc, c + PRESS_LAT + LONG);
`endif
    idle_low(10);

    // Reset asserted mid-debounce clears everything without a clock edge.
    btn_raw = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_level", int'(btn_level), 0);
    check("async_press", int'(btn_press), 0);
    check("async_long", int'(btn_long), 0);
    check("async_run", int'(run), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    expect_press(1'b1);
    repeat (9) @(negedge clk);
    idle_low(12);

    check("missed_presses", exp_q.size(), 0);
    check("long_pulse_count", long_count, LONG_EXP);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
